// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the status-LED blink/PWM blocks.
package led_blink_pkg;

    localparam int CH_STATE_W = 2;

    typedef enum logic [CH_STATE_W-1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DIM    = 2'd2,
        LOST   = 2'd3
    } ch_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// PWM timebase shared by LED drivers: prescaler tick, frame counter and blink phase.
module led_tick_gen
    import led_blink_pkg::*;
#(
    parameter int TICK_DIV     = 2500,
    parameter int FRAME_W      = 10,
    parameter int BLINK_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    output logic               tick_o,
    output logic [FRAME_W-1:0] fc_o,
    output logic               frame_wrap_o,
    output logic               blink_phase_o,
    output logic               blink_rise_o
);
    localparam int PC_W = sel_width(TICK_DIV);
    localparam int BC_W = sel_width(BLINK_FRAMES);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               tick_q, tick_d;
    logic [FRAME_W-1:0] fc_q, fc_d;
    logic [BC_W-1:0]    bc_q, bc_d;
    logic               phase_q, phase_d;
    logic               pc_last, bc_last;

    assign pc_last = (pc_q == PC_LAST);
    assign bc_last = (bc_q == BC_LAST);

    // Both strobes describe the edge about to happen, so consumers act on it in step.
    assign frame_wrap_o = tick_q & (&fc_q);
    assign blink_rise_o = frame_wrap_o & bc_last & ~phase_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d    = pc_last ? '0 : pc_q + 1'b1;
        tick_d  = pc_last;
        fc_d    = tick_q ? fc_q + 1'b1 : fc_q;
        bc_d    = bc_q;
        phase_d = phase_q;
        if (frame_wrap_o) begin
            bc_d    = bc_last ? '0 : bc_q + 1'b1;
            phase_d = phase_q ^ bc_last;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            tick_q  <= 1'b0;
            fc_q    <= '0;
            bc_q    <= '0;
            phase_q <= 1'b0;
        end else if (clr_i) begin
            pc_q    <= '0;
            tick_q  <= 1'b0;
            fc_q    <= '0;
            bc_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tick_q  <= tick_d;
            fc_q    <= fc_d;
            bc_q    <= bc_d;
            phase_q <= phase_d;
        end
    end

    assign tick_o        = tick_q;
    assign fc_o          = fc_q;
    assign blink_phase_o = phase_q;

endmodule

// File: rtl/led_blink_pwm_mc.sv
// Per-port status LEDs: selected = steady, others = PWM-dimmed, lost selected = timed blink.
// Define LED_BLINK_GAMMA_EN for a square-law dimming curve instead of linear.
module led_blink_pwm_mc
    import led_blink_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int TICK_DIV     = 2500,
    parameter int FRAME_W      = 10,
    parameter int BLINK_FRAMES = 4,
    parameter int LOST_BLINKS  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       c_done,
    input  logic [N_CH-1:0]            rx_ok,
    input  logic [sel_width(N_CH)-1:0] sel,
    input  logic [FRAME_W-1:0]         dim_duty,
    output logic [N_CH-1:0]            led_on,
    output logic                       tick,
    output logic                       blink_phase
);
    localparam int SEL_W  = sel_width(N_CH);
    localparam int LOST_W = sel_width(LOST_BLINKS);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_BLINKS - 1);

    logic               clr;
    logic [FRAME_W-1:0] fc;
    logic               frame_wrap;
    logic               blink_rise;

    assign clr = ~c_done;

    led_tick_gen #(
        .TICK_DIV    (TICK_DIV),
        .FRAME_W     (FRAME_W),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_tick_gen (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .tick_o       (tick),
        .fc_o         (fc),
        .frame_wrap_o (frame_wrap),
        .blink_phase_o(blink_phase),
        .blink_rise_o (blink_rise)
    );

    logic [FRAME_W-1:0] duty_src, duty_q, duty_d;
    logic               duty_vld_q, duty_load;

`ifdef LED_BLINK_GAMMA_EN
    logic [2*FRAME_W-1:0] duty_sq;
    assign duty_sq  = {{FRAME_W{1'b0}}, dim_duty} * {{FRAME_W{1'b0}}, dim_duty};
    assign duty_src = (&dim_duty) ? {FRAME_W{1'b1}} : FRAME_W'(duty_sq >> FRAME_W);
`else
    assign duty_src = dim_duty;
`endif

    // Also load once right after reset/clear so the first frame uses the live duty.
    assign duty_load = frame_wrap | ~duty_vld_q;
    assign duty_d    = duty_load ? duty_src : duty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q     <= '0;
            duty_vld_q <= 1'b0;
        end else if (clr) begin
            duty_q     <= '0;
            duty_vld_q <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            duty_vld_q <= 1'b1;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(ch);

        ch_state_t         state_q, state_d;
        logic [LOST_W-1:0] lost_q, lost_d;
        logic              led_q, led_d;
        logic              sel_match;

        assign sel_match = (sel == CH_IDX);

        always_comb begin
            state_d = state_q;
            lost_d  = lost_q;
            case (state_q)
                IDLE: begin
                    if (rx_ok[ch]) state_d = sel_match ? ACTIVE : DIM;
                end
                ACTIVE: begin
                    if (!sel_match) begin
                        state_d = rx_ok[ch] ? DIM : IDLE;
                    end else if (!rx_ok[ch]) begin
                        state_d = LOST;
                        lost_d  = '0;
                    end
                end
                DIM: begin
                    if (!rx_ok[ch])     state_d = IDLE;
                    else if (sel_match) state_d = ACTIVE;
                end
                LOST: begin
                    if (rx_ok[ch]) begin
                        state_d = sel_match ? ACTIVE : DIM;
                        lost_d  = '0;
                    end else if (!sel_match) begin
                        state_d = IDLE;
                        lost_d  = '0;
                    end else if (blink_rise) begin
                        if (lost_q == LOST_LAST) begin
                            state_d = IDLE;
                            lost_d  = '0;
                        end else begin
                            lost_d = lost_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            led_d = 1'b0;
            case (state_q)
                ACTIVE:  led_d = 1'b1;
                DIM:     led_d = (&duty_q) | (fc < duty_q);
                LOST:    led_d = blink_phase;
                default: led_d = 1'b0;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                lost_q  <= '0;
                led_q   <= 1'b0;
            end else if (clr) begin
                state_q <= IDLE;
                lost_q  <= '0;
                led_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                lost_q  <= lost_d;
                led_q   <= led_d;
            end
        end

        assign led_on[ch] = led_q;
    end

endmodule

// File: tb/tb_led_blink_pwm_mc.sv
// Directed bench for led_blink_pwm_mc with a short timebase (4 clk ticks, 16-tick frames).
module tb_led_blink_pwm_mc;
    localparam int N_CH         = 3;
    localparam int TICK_DIV     = 4;
    localparam int FRAME_W      = 4;
    localparam int BLINK_FRAMES = 4;
    localparam int LOST_BLINKS  = 3;
    localparam int FRAME_CLK    = TICK_DIV * (1 << FRAME_W);
    localparam int HALF_CLK     = FRAME_CLK * BLINK_FRAMES;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                c_done;
    logic [N_CH-1:0]     rx_ok;
    logic [1:0]          sel;
    logic [FRAME_W-1:0]  dim_duty;
    logic [N_CH-1:0]     led_on;
    logic                tick;
    logic                blink_phase;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    led_blink_pwm_mc #(
        .N_CH        (N_CH),
        .TICK_DIV    (TICK_DIV),
        .FRAME_W     (FRAME_W),
        .BLINK_FRAMES(BLINK_FRAMES),
        .LOST_BLINKS (LOST_BLINKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .c_done     (c_done),
        .rx_ok      (rx_ok),
        .sel        (sel),
        .dim_duty   (dim_duty),
        .led_on     (led_on),
        .tick       (tick),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    // Clock edges since the timebase last started from zero.
    always @(posedge clk or posedge rst) begin
        if (rst)         cyc <= 0;
        else if (!c_done) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Blink phase expected after edge x: toggles every HALF_CLK, first rise at edge HALF_CLK+1.
    function automatic int phase_model(input int x);
        return ((x - 1) / HALF_CLK) % 2;
    endfunction

    // Lit clocks per frame for a DIM channel at a given dim_duty.
    function automatic int dim_on_clk(input int d);
        int eff;
        if (d == (1 << FRAME_W) - 1) return FRAME_CLK;
`ifdef LED_BLINK_GAMMA_EN
        eff = (d * d) >> FRAME_W;
`else
        eff = d;
`endif
        return eff * TICK_DIV;
    endfunction

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) check("wait_timeout", cyc, n);
    endtask

    task automatic count_high(input int first, input int last, output int n0, output int n1, output int n2);
        n0 = 0; n1 = 0; n2 = 0;
        for (int e = first; e <= last; e++) begin
            wait_cyc(e);
            n0 += int'(led_on[0]);
            n1 += int'(led_on[1]);
            n2 += int'(led_on[2]);
        end
    endtask

    // Called on the negedge right after the timebase restarts (cyc == 0).
    task automatic tick_start(input string tag);
        int first, second;
        first  = -1;
        second = -1;
        for (int i = 0; i < 20 && second < 0; i++) begin
            @(negedge clk);
            if (tick) begin
                if (first < 0) first = cyc;
                else           second = cyc;
            end
        end
        check({tag, "_first"}, first, TICK_DIV);
        check({tag, "_period"}, second - first, TICK_DIV);
    endtask

    // Entry into LOST at edge entry (just after a blink rise); expect 3 full periods then dark.
    task automatic lost_window(input string tag, input int entry);
        int errs, lit, n0, n1, n2, last;
        errs = 0;
        lit  = 0;
        last = entry + LOST_BLINKS * 2 * HALF_CLK - 1;
        for (int e = entry + 1; e <= last; e++) begin
            wait_cyc(e);
            if (int'(led_on[0]) != phase_model(e - 1)) errs++;
            lit += int'(led_on[0]);
        end
        check({tag, "_follow_errs"}, errs, 0);
        check({tag, "_lit_clk"}, lit, LOST_BLINKS * HALF_CLK - 1);
        count_high(last + 1, last + 13, n0, n1, n2);
        check({tag, "_expired"}, n0, 0);
    endtask

    initial begin
        int n0, n1, n2, a0, a1, a2;
        c_done   = 1'b1;
        rx_ok    = '0;
        sel      = 2'd0;
        dim_duty = 4'd4;

        repeat (2) @(negedge clk);
        check("rst_led", int'(led_on), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_blink", int'(blink_phase), 0);

        // Steady ACTIVE on ch0, 4/16 PWM on ch1, ch2 idle.
        rx_ok = 3'b011;
        rst   = 1'b0;
        tick_start("tick_boot");
        count_high(100, 163, n0, n1, n2);
        check("active_steady", n0, FRAME_CLK);
        check("dim4_lit", n1, dim_on_clk(4));
        check("idle_dark", n2, 0);

        // Mid-frame duty change takes effect only at the next frame wrap (edge 257).
        count_high(194, 213, a0, a1, a2);
        dim_duty = 4'd12;
        count_high(214, 257, n0, n1, n2);
        check("duty_old_frame", a1 + n1, dim_on_clk(4));
        count_high(258, 321, n0, n1, n2);
        check("duty_new_frame", n1, dim_on_clk(12));

        // Out-of-range select: everything receiving goes DIM, duty extremes.
        wait_cyc(330);
        sel      = 2'd3;
        dim_duty = 4'd0;
        count_high(390, 453, n0, n1, n2);
        check("oor_duty0_ch0", n0, 0);
        check("oor_duty0_ch1", n1, 0);
        wait_cyc(455);
        dim_duty = 4'd15;
        wait_cyc(512);
        check("blink_lit_half", int'(blink_phase), 1);
        wait_cyc(513);
        check("blink_dark_half", int'(blink_phase), 0);
        count_high(520, 583, n0, n1, n2);
        check("oor_duty15_ch0", n0, FRAME_CLK);
        check("oor_duty15_ch1", n1, FRAME_CLK);
        check("oor_idle_ch2", n2, 0);

        // Back to ch0 selected; duty 8 (linear 8 ticks, gamma 4 ticks).
        wait_cyc(600);
        sel      = 2'd0;
        dim_duty = 4'd8;
        count_high(650, 713, n0, n1, n2);
        check("reselect_ch0", n0, FRAME_CLK);
        check("duty8_ch1", n1, dim_on_clk(8));

        // Lose ch0 input right after a blink rise.
        wait_cyc(1281);
        check("blink_at_drop", int'(blink_phase), 1);
        rx_ok[0] = 1'b0;
        lost_window("lost1", 1282);

        // Re-arm, lose again across one blink rise, then recover within 2 clk.
        wait_cyc(2900);
        rx_ok[0] = 1'b1;
        wait_cyc(3200);
        rx_ok[0] = 1'b0;
        wait_cyc(3600);
        rx_ok[0] = 1'b1;
        wait_cyc(3601);
        check("recover_clk1", int'(led_on[0]), 0);
        wait_cyc(3602);
        check("recover_clk2", int'(led_on[0]), 1);
        count_high(3603, 3841, n0, n1, n2);
        check("recover_steady", n0, 3841 - 3603 + 1);

        // A fresh loss must again show the full blink count (lost counter was cleared).
        rx_ok[0] = 1'b0;
        lost_window("lost2", 3842);

        // Asynchronous reset between clock edges.
        wait_cyc(5400);
        rx_ok[0] = 1'b1;
        wait_cyc(5410);
        check("pre_rst_led0", int'(led_on[0]), 1);
        check("pre_rst_blink", int'(blink_phase), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", int'(led_on), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_blink", int'(blink_phase), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick_start("tick_after_rst");

        // c_done low clears synchronously at the next edge.
        wait_cyc(300);
        check("pre_clr_blink", int'(blink_phase), 1);
        c_done = 1'b0;
        #1;
        check("clr_not_yet", int'(led_on[0]), 1);
        @(posedge clk);
        #1;
        check("clr_led", int'(led_on), 0);
        check("clr_tick", int'(tick), 0);
        check("clr_blink", int'(blink_phase), 0);
        repeat (3) @(negedge clk);
        check("clr_held_led", int'(led_on), 0);
        c_done = 1'b1;
        tick_start("tick_after_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
